// File: rtl/dco_code_sequencer.sv
// DCO code sequencer: handles config handshakes, sleep/wake sequencing, one-LSB ramping
// toward a target code, row/column thermometer select generation and first-order dither.
module dco_code_sequencer #(
  parameter int COL_BITS      = 14,
  parameter int ROW_BITS      = 16,
  parameter int CODE_BITS     = 8,
  parameter int FRAC_BITS     = 4,
  parameter int STEP_INTERVAL = 8,
  parameter int WAKE_CYCLES   = 32
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [CODE_BITS-1:0] cfg_code,
  input  logic [FRAC_BITS-1:0] cfg_frac,
  input  logic [7:0]           cfg_regulator,
  input  logic                 cfg_sleep,
  output logic [COL_BITS-1:0]  col_sel_b,
  output logic [ROW_BITS-1:0]  row_sel_b,
  output logic [7:0]           code_regulator,
  output logic                 dither,
  output logic                 sleep_b,
  output logic                 busy,
  output logic                 settled
);
  // state   | meaning
  // S_SLEEP | DCO asleep, selects all ones, accepts config
  // S_WAKE  | sleep_b released, code 0, waiting WAKE_CYCLES
  // S_RAMP  | stepping current code toward target every STEP_INTERVAL cycles
  // S_HOLD  | current == target, accepts config

  localparam int MAX_CODE = ROW_BITS * COL_BITS - 1;
  localparam int ROW_W    = $clog2(ROW_BITS);
  localparam int COL_W    = $clog2(COL_BITS);
  localparam int WAKE_W   = $clog2(WAKE_CYCLES + 1);
  localparam int STEP_W   = $clog2(STEP_INTERVAL + 1);
  localparam logic [CODE_BITS-1:0] MAX_CODE_C = CODE_BITS'(MAX_CODE);
  localparam logic [COL_W-1:0]     COL_LAST   = COL_W'(COL_BITS - 1);

  typedef enum logic [1:0] {S_SLEEP, S_WAKE, S_RAMP, S_HOLD} state_t;

  state_t                 state;
  logic [ROW_W-1:0]       row_q;
  logic [COL_W-1:0]       col_q;
  logic [CODE_BITS-1:0]   lin_q;
  logic [CODE_BITS-1:0]   tgt_q;
  logic [FRAC_BITS-1:0]   frac_q;
  logic [FRAC_BITS-1:0]   acc_q;
  logic [WAKE_W-1:0]      wake_cnt;
  logic [STEP_W-1:0]      step_cnt;

  logic                   accept;
  logic [CODE_BITS-1:0]   code_clamped;
  logic [FRAC_BITS:0]     acc_sum;
  logic [ROW_W-1:0]       row_up, row_dn;
  logic [COL_W-1:0]       col_up, col_dn;

  function automatic logic [ROW_BITS-1:0] row_therm_b(input logic [ROW_W-1:0] r);
    logic [ROW_BITS-1:0] v;
    for (int i = 0; i < ROW_BITS; i++) v[i] = (i > int'(r));
    return v;
  endfunction

  function automatic logic [COL_BITS-1:0] col_therm_b(input logic [COL_W-1:0] c);
    logic [COL_BITS-1:0] v;
    for (int j = 0; j < COL_BITS; j++) v[j] = (j > int'(c));
    return v;
  endfunction

  assign accept       = cfg_valid && cfg_ready;
  assign code_clamped = (cfg_code > MAX_CODE_C) ? MAX_CODE_C : cfg_code;
  assign acc_sum      = {1'b0, acc_q} + {1'b0, frac_q};

  // Row/column neighbours of the current code; the linear counter only feeds the compare.
  always_comb begin
    row_up = row_q;
    col_up = col_q + 1'b1;
    if (col_q == COL_LAST) begin
      row_up = row_q + 1'b1;
      col_up = '0;
    end
    row_dn = row_q;
    col_dn = col_q - 1'b1;
    if (col_q == '0) begin
      row_dn = row_q - 1'b1;
      col_dn = COL_LAST;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= S_SLEEP;
      row_q          <= '0;
      col_q          <= '0;
      lin_q          <= '0;
      tgt_q          <= '0;
      frac_q         <= '0;
      acc_q          <= '0;
      wake_cnt       <= '0;
      step_cnt       <= '0;
      cfg_ready      <= 1'b1;
      col_sel_b      <= '1;
      row_sel_b      <= '1;
      code_regulator <= '0;
      dither         <= 1'b0;
      sleep_b        <= 1'b0;
      busy           <= 1'b0;
      settled        <= 1'b0;
    end else begin
      case (state)
        S_SLEEP: begin
          if (accept) begin
            code_regulator <= cfg_regulator;
            frac_q         <= cfg_frac;
            if (!cfg_sleep) begin
              tgt_q     <= code_clamped;
              state     <= S_WAKE;
              wake_cnt  <= WAKE_W'(WAKE_CYCLES);
              sleep_b   <= 1'b1;
              cfg_ready <= 1'b0;
              busy      <= 1'b1;
              row_sel_b <= row_therm_b(row_q);
              col_sel_b <= col_therm_b(col_q);
            end
          end
        end
        S_WAKE: begin
          if (wake_cnt == WAKE_W'(1)) begin
            state    <= S_RAMP;
            step_cnt <= STEP_W'(STEP_INTERVAL);
          end else begin
            wake_cnt <= wake_cnt - 1'b1;
          end
        end
        S_RAMP: begin
          acc_q  <= acc_sum[FRAC_BITS-1:0];
          dither <= acc_sum[FRAC_BITS];
          if (lin_q == tgt_q) begin
            state     <= S_HOLD;
            busy      <= 1'b0;
            settled   <= 1'b1;
            cfg_ready <= 1'b1;
          end else if (step_cnt == STEP_W'(1)) begin
            step_cnt <= STEP_W'(STEP_INTERVAL);
            if (lin_q < tgt_q) begin
              row_q     <= row_up;
              col_q     <= col_up;
              lin_q     <= lin_q + 1'b1;
              row_sel_b <= row_therm_b(row_up);
              col_sel_b <= col_therm_b(col_up);
            end else begin
              row_q     <= row_dn;
              col_q     <= col_dn;
              lin_q     <= lin_q - 1'b1;
              row_sel_b <= row_therm_b(row_dn);
              col_sel_b <= col_therm_b(col_dn);
            end
          end else begin
            step_cnt <= step_cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (accept && cfg_sleep) begin
            // Target is kept; the next wake restarts the ramp from code 0.
            state          <= S_SLEEP;
            code_regulator <= cfg_regulator;
            frac_q         <= cfg_frac;
            row_q          <= '0;
            col_q          <= '0;
            lin_q          <= '0;
            acc_q          <= '0;
            dither         <= 1'b0;
            sleep_b        <= 1'b0;
            settled        <= 1'b0;
            row_sel_b      <= '1;
            col_sel_b      <= '1;
          end else begin
            acc_q  <= acc_sum[FRAC_BITS-1:0];
            dither <= acc_sum[FRAC_BITS];
            if (accept) begin
              code_regulator <= cfg_regulator;
              frac_q         <= cfg_frac;
              if (code_clamped != tgt_q) begin
                tgt_q     <= code_clamped;
                state     <= S_RAMP;
                step_cnt  <= STEP_W'(STEP_INTERVAL);
                settled   <= 1'b0;
                busy      <= 1'b1;
                cfg_ready <= 1'b0;
              end
            end
          end
        end
        default: state <= S_SLEEP;
      endcase
    end
  end

endmodule

// File: tb/tb_dco_code_sequencer.sv
// Randomized self-checking bench for dco_code_sequencer against a cycle-level
// behavioural model built on plain integer arithmetic.
module tb_dco_code_sequencer;
  localparam int COL_BITS      = 14;
  localparam int ROW_BITS      = 16;
  localparam int CODE_BITS     = 8;
  localparam int FRAC_BITS     = 4;
  localparam int STEP_INTERVAL = 8;
  localparam int WAKE_CYCLES   = 32;
  localparam int MAX_CODE      = ROW_BITS * COL_BITS - 1;
  localparam int M_SLEEP = 0, M_WAKE = 1, M_RAMP = 2, M_HOLD = 3;

  logic                 clock = 1'b0;
  logic                 reset_n;
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic [CODE_BITS-1:0] cfg_code;
  logic [FRAC_BITS-1:0] cfg_frac;
  logic [7:0]           cfg_regulator;
  logic                 cfg_sleep;
  logic [COL_BITS-1:0]  col_sel_b;
  logic [ROW_BITS-1:0]  row_sel_b;
  logic [7:0]           code_regulator;
  logic                 dither;
  logic                 sleep_b;
  logic                 busy;
  logic                 settled;

  always #5 clock = ~clock;

  dco_code_sequencer #(
    .COL_BITS(COL_BITS), .ROW_BITS(ROW_BITS), .CODE_BITS(CODE_BITS),
    .FRAC_BITS(FRAC_BITS), .STEP_INTERVAL(STEP_INTERVAL), .WAKE_CYCLES(WAKE_CYCLES)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_code(cfg_code),
    .cfg_frac(cfg_frac), .cfg_regulator(cfg_regulator), .cfg_sleep(cfg_sleep),
    .col_sel_b(col_sel_b), .row_sel_b(row_sel_b), .code_regulator(code_regulator),
    .dither(dither), .sleep_b(sleep_b), .busy(busy), .settled(settled)
  );

  int n_checks = 0;
  int n_errors = 0;

  int m_mode, m_cur, m_tgt, m_frac, m_acc, m_reg, m_dither;
  int m_wake_elapsed, m_since_step;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [ROW_BITS-1:0] exp_row_b(input int code);
    logic [31:0] m;
    m = (32'd1 << (code / COL_BITS + 1)) - 32'd1;
    return ~m[ROW_BITS-1:0];
  endfunction

  function automatic logic [COL_BITS-1:0] exp_col_b(input int code);
    logic [31:0] m;
    m = (32'd1 << (code % COL_BITS + 1)) - 32'd1;
    return ~m[COL_BITS-1:0];
  endfunction

  task automatic model_reset();
    m_mode = M_SLEEP; m_cur = 0; m_tgt = 0; m_frac = 0; m_acc = 0;
    m_reg = 0; m_dither = 0; m_wake_elapsed = 0; m_since_step = 0;
  endtask

  task automatic dither_step();
    int s;
    s = m_acc + m_frac;
    m_dither = (s >= (1 << FRAC_BITS)) ? 1 : 0;
    m_acc = s % (1 << FRAC_BITS);
  endtask

  // Advances the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit acc_ok;
    int clamp;
    acc_ok = cfg_valid && (m_mode == M_SLEEP || m_mode == M_HOLD);
    clamp = (int'(cfg_code) > MAX_CODE) ? MAX_CODE : int'(cfg_code);
    case (m_mode)
      M_SLEEP: if (acc_ok) begin
        m_reg = cfg_regulator; m_frac = cfg_frac;
        if (!cfg_sleep) begin m_tgt = clamp; m_mode = M_WAKE; m_wake_elapsed = 0; end
      end
      M_WAKE: begin
        m_wake_elapsed++;
        if (m_wake_elapsed == WAKE_CYCLES) begin m_mode = M_RAMP; m_since_step = 0; end
      end
      M_RAMP: begin
        dither_step();
        if (m_cur == m_tgt) m_mode = M_HOLD;
        else begin
          m_since_step++;
          if (m_since_step == STEP_INTERVAL) begin
            m_since_step = 0;
            m_cur = m_cur + ((m_tgt > m_cur) ? 1 : -1);
          end
        end
      end
      default: begin
        if (acc_ok && cfg_sleep) begin
          m_mode = M_SLEEP; m_cur = 0; m_acc = 0; m_dither = 0;
          m_reg = cfg_regulator; m_frac = cfg_frac;
        end else begin
          dither_step();
          if (acc_ok) begin
            m_reg = cfg_regulator; m_frac = cfg_frac;
            if (clamp != m_tgt) begin m_tgt = clamp; m_mode = M_RAMP; m_since_step = 0; end
          end
        end
      end
    endcase
  endtask

  task automatic compare_all();
    check("cfg_ready", cfg_ready, (m_mode == M_SLEEP || m_mode == M_HOLD));
    check("sleep_b", sleep_b, (m_mode != M_SLEEP));
    check("busy", busy, (m_mode == M_WAKE || m_mode == M_RAMP));
    check("settled", settled, (m_mode == M_HOLD));
    check("dither", dither, m_dither);
    check("code_regulator", code_regulator, m_reg);
    check("row_sel_b", row_sel_b, (m_mode == M_SLEEP) ? {ROW_BITS{1'b1}} : exp_row_b(m_cur));
    check("col_sel_b", col_sel_b, (m_mode == M_SLEEP) ? {COL_BITS{1'b1}} : exp_col_b(m_cur));
  endtask

  task automatic tick();
    model_step();
    @(posedge clock);
    @(negedge clock);
    compare_all();
  endtask

  task automatic send(input int code, input int frac, input int regv, input bit slp);
    cfg_valid = 1'b1;
    cfg_code = CODE_BITS'(code);
    cfg_frac = FRAC_BITS'(frac);
    cfg_regulator = 8'(regv);
    cfg_sleep = slp;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic run_to_hold(input string tag, input int limit);
    for (int i = 0; i < limit && m_mode != M_HOLD; i++) tick();
    check(tag, settled, 1);
  endtask

  task automatic count_ones(input int cycles, output int ones);
    ones = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      ones += int'(dither);
    end
  endtask

  initial begin
    int ones;
    reset_n = 1'b0;
    cfg_valid = 1'b0; cfg_code = '0; cfg_frac = '0; cfg_regulator = '0; cfg_sleep = 1'b0;
    model_reset();
    repeat (3) @(negedge clock);
    compare_all();
    reset_n = 1'b1;
    tick();

    // Wake and ramp to code 5
    send(5, 0, 8'h40, 1'b0);
    check("wake_sleep_b", sleep_b, 1);
    run_to_hold("settle_5", 200);
    check("c5_row", row_sel_b, 16'hFFFE);
    check("c5_col", col_sel_b, 14'h3FC0);
    check("c5_reg", code_regulator, 8'h40);

    // Column wrap 13 -> 15
    send(13, 0, 8'h40, 1'b0);
    run_to_hold("settle_13", 200);
    send(15, 0, 8'h40, 1'b0);
    for (int i = 0; i < 40 && m_cur != 14; i++) tick();
    check("c14_row", row_sel_b, 16'hFFFC);
    check("c14_col", col_sel_b, 14'h3FFE);
    run_to_hold("settle_15", 40);
    check("c15_col", col_sel_b, 14'h3FFC);

    // Clamp to MAX_CODE
    send(8'hFF, 0, 8'h40, 1'b0);
    run_to_hold("settle_max", 1800);
    check("max_row", row_sel_b, 16'h0000);
    check("max_col", col_sel_b, 14'h0000);

    // Dither density in HOLD, equal target keeps HOLD
    send(8'hFF, 8, 8'h41, 1'b0);
    check("eq_tgt_hold", settled, 1);
    count_ones(8, ones);
    check("dither_frac8", ones, 4);
    send(MAX_CODE, 4, 8'h42, 1'b0);
    count_ones(8, ones);
    check("dither_frac4", ones, 2);
    send(MAX_CODE, 0, 8'h43, 1'b0);
    count_ones(8, ones);
    check("dither_frac0", ones, 0);

    // Sleep request stalled during RAMP until HOLD
    send(200, 3, 8'h44, 1'b0);
    cfg_valid = 1'b1; cfg_sleep = 1'b1; cfg_code = 8'd50; cfg_frac = 4'd7; cfg_regulator = 8'h55;
    tick();
    check("stall_ready", cfg_ready, 0);
    for (int i = 0; i < 400 && m_mode != M_SLEEP; i++) tick();
    cfg_valid = 1'b0;
    check("slept_sleep_b", sleep_b, 0);
    check("slept_row", row_sel_b, 16'hFFFF);
    check("slept_col", col_sel_b, 14'h3FFF);
    check("slept_dither", dither, 0);
    check("slept_reg", code_regulator, 8'h55);

    // Asynchronous reset mid-ramp at code 3 of 10
    send(10, 5, 8'h66, 1'b0);
    for (int i = 0; i < 100 && m_cur != 3; i++) tick();
    check("pre_rst_busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_sleep_b", sleep_b, 0);
    check("rst_row", row_sel_b, 16'hFFFF);
    check("rst_col", col_sel_b, 14'h3FFF);
    check("rst_reg", code_regulator, 0);
    check("rst_ready", cfg_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_settled", settled, 0);
    check("rst_dither", dither, 0);
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
    tick();

    // Randomized traffic
    for (int c = 0; c < 5000; c++) begin
      cfg_valid = ($urandom_range(0, 3) == 0);
      cfg_code = CODE_BITS'($urandom_range(0, 255));
      cfg_frac = FRAC_BITS'($urandom_range(0, 15));
      cfg_regulator = 8'($urandom_range(0, 255));
      cfg_sleep = ($urandom_range(0, 7) == 0);
      tick();
    end
    cfg_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
